// File: rtl/fifo_pkg.sv
// Shared constants and the status bundle for the register-file FIFO.
// The status struct is reused wherever the six FIFO flags travel together.
package fifo_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/strobe/status bundle between the producer/consumer side and the FIFO controller.
interface fifo_ctrl_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
);
  import fifo_pkg::*;

  logic              push;
  logic              pop;
  logic              clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, clr,
    input  wr_en, wr_addr, rd_addr, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop, clr,
    output wr_en, wr_addr, rd_addr, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Single wrapping FIFO pointer; the explicit wrap keeps non-power-of-two depths legal.
module fifo_ptr #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a DEPTH-entry register-file FIFO.
// Flags decode the registered count, so they follow the causing edge by one cycle.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic        clk,
  input  logic        rst,
  fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_ok, pop_ok;
  logic              wr_inc, rd_inc;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  fifo_status_t      st;

  always_comb begin
    st              = '0;
    st.full         = (count_q == DEPTH_C);
    st.empty        = (count_q == '0);
    st.almost_full  = (count_q >= AF_C);
    st.almost_empty = (count_q <= AE_C);
    st.overflow     = ovf_q;
    st.underflow    = udf_q;
  end

  // A pop frees a slot this cycle, so a push into a full FIFO is accepted alongside it.
  assign push_ok = bus.push & (~st.full | bus.pop);
  assign pop_ok  = bus.pop & ~st.empty;
  assign wr_inc  = push_ok & ~bus.clr;
  assign rd_inc  = pop_ok & ~bus.clr;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q | (bus.push & ~push_ok);
    udf_d   = udf_q | (bus.pop & ~pop_ok);
    if (bus.clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.clr),
    .inc_i (wr_inc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.clr),
    .inc_i (rd_inc),
    .ptr_o (rd_ptr)
  );

  assign bus.wr_en        = wr_inc;
  assign bus.wr_addr      = wr_ptr;
  assign bus.rd_addr      = rd_ptr;
  assign bus.count        = count_q;
  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;

  // Occupancy must agree with the pointer distance, with equal pointers meaning 0 or DEPTH.
  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
  a_count_ptrs: assert property (@(posedge clk) disable iff (rst)
    ((32'(wr_ptr) + DEPTH - 32'(rd_ptr)) % DEPTH) == (32'(count_q) % DEPTH));

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_ctrl_if #(.DEPTH(8)) b8 ();
  fifo_ctrl_if #(.DEPTH(5)) b5 ();

  fifo_ctrl #(.DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  fifo_ctrl #(.DEPTH(5)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  typedef struct {
    logic push;
    logic pop;
    logic clr;
    logic we;
    int   wa;
    int   ra;
    int   cnt;
    logic ov;
    logic un;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic p, input logic q, input logic c, input logic we,
                              input int wa, input int ra, input int cnt,
                              input logic ov, input logic un);
    vec_t v;
    v = '{p, q, c, we, wa, ra, cnt, ov, un};
    vecs.push_back(v);
  endfunction

  // Called at posedge+1: mid-cycle checks of the combinational strobe/addresses,
  // then post-edge checks of the registered count and its flags.
  task automatic apply8(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    tag = $sformatf("v%0d", idx);
    b8.push = v.push;
    b8.pop  = v.pop;
    b8.clr  = v.clr;
    #3;
    chk({tag, "_wr_en"}, int'(b8.wr_en), int'(v.we));
    chk({tag, "_wr_addr"}, int'(b8.wr_addr), v.wa);
    chk({tag, "_rd_addr"}, int'(b8.rd_addr), v.ra);
    @(posedge clk);
    #1;
    chk({tag, "_count"}, int'(b8.count), v.cnt);
    chk({tag, "_full"}, int'(b8.full), int'(v.cnt == 8));
    chk({tag, "_empty"}, int'(b8.empty), int'(v.cnt == 0));
    chk({tag, "_afull"}, int'(b8.almost_full), int'(v.cnt >= 6));
    chk({tag, "_aempty"}, int'(b8.almost_empty), int'(v.cnt <= 2));
    chk({tag, "_overflow"}, int'(b8.overflow), int'(v.ov));
    chk({tag, "_underflow"}, int'(b8.underflow), int'(v.un));
  endtask

  task automatic step5(input string tag, input logic p, input logic q, input logic we,
                       input int wa, input int ra, input int cnt, input logic ov);
    b5.push = p;
    b5.pop  = q;
    b5.clr  = 1'b0;
    #3;
    chk({tag, "_wr_en"}, int'(b5.wr_en), int'(we));
    chk({tag, "_wr_addr"}, int'(b5.wr_addr), wa);
    chk({tag, "_rd_addr"}, int'(b5.rd_addr), ra);
    chk({tag, "_wa_range"}, int'(b5.wr_addr < 3'd5), 1);
    chk({tag, "_ra_range"}, int'(b5.rd_addr < 3'd5), 1);
    @(posedge clk);
    #1;
    chk({tag, "_count"}, int'(b5.count), cnt);
    chk({tag, "_full"}, int'(b5.full), int'(cnt == 5));
    chk({tag, "_afull"}, int'(b5.almost_full), int'(cnt >= 3));
    chk({tag, "_overflow"}, int'(b5.overflow), int'(ov));
  endtask

  initial begin
    int wa5[7];
    int ra5[7];
    wa5 = '{1, 2, 3, 4, 0, 1, 2};
    ra5 = '{0, 1, 2, 3, 4, 0, 1};

    b8.push = 1'b0; b8.pop = 1'b0; b8.clr = 1'b0;
    b5.push = 1'b0; b5.pop = 1'b0; b5.clr = 1'b0;

    // Fill 8, rotate while full, overflow, drain, underflow, push+pop on empty.
    for (int i = 0; i < 8; i++) add(1, 0, 0, 1, i, 0, i + 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, i, i, 8, 0, 0);
    add(1, 0, 0, 0, 3, 3, 8, 1, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 3, (3 + k) % 8, 7 - k, 1, 0);
    add(0, 1, 0, 0, 3, 3, 0, 1, 1);
    add(1, 1, 0, 1, 3, 3, 1, 1, 1);
    // Flush, mid-fill to 4, flush with a push pending, then idle.
    add(0, 0, 1, 0, 4, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1, i, 0, i + 1, 0, 0);
    add(1, 0, 1, 0, 4, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Underflow then a partial fill, so the async reset has state to discard.
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, i, 0, i + 1, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_empty", int'(b8.empty), 1);
    chk("rst_aempty", int'(b8.almost_empty), 1);
    chk("rst_full", int'(b8.full), 0);
    chk("rst_afull", int'(b8.almost_full), 0);
    chk("rst_count", int'(b8.count), 0);
    chk("rst_wr_addr", int'(b8.wr_addr), 0);
    chk("rst_rd_addr", int'(b8.rd_addr), 0);
    chk("rst_wr_en", int'(b8.wr_en), 0);
    chk("rst_ovf", int'(b8.overflow), 0);
    chk("rst_udf", int'(b8.underflow), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply8(i);

    // Asynchronous reset mid-cycle with count=3 and underflow set.
    b8.push = 1'b0;
    b8.pop  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", int'(b8.count), 0);
    chk("arst_wr_addr", int'(b8.wr_addr), 0);
    chk("arst_rd_addr", int'(b8.rd_addr), 0);
    chk("arst_empty", int'(b8.empty), 1);
    chk("arst_full", int'(b8.full), 0);
    chk("arst_aempty", int'(b8.almost_empty), 1);
    chk("arst_afull", int'(b8.almost_full), 0);
    chk("arst_wr_en", int'(b8.wr_en), 0);
    chk("arst_udf", int'(b8.underflow), 0);
    chk("arst_ovf", int'(b8.overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // DEPTH=5: one entry, then 7 push/pop pairs crossing the 4->0 wrap, then fill and overflow.
    step5("d5_p0", 1, 0, 1, 0, 0, 1, 0);
    for (int j = 0; j < 7; j++)
      step5($sformatf("d5_pp%0d", j), 1, 1, 1, wa5[j], ra5[j], 1, 0);
    step5("d5_f2", 1, 0, 1, 3, 2, 2, 0);
    step5("d5_f3", 1, 0, 1, 4, 2, 3, 0);
    step5("d5_f4", 1, 0, 1, 0, 2, 4, 0);
    step5("d5_f5", 1, 0, 1, 1, 2, 5, 0);
    step5("d5_ovf", 1, 0, 0, 2, 2, 5, 1);
    b5.push = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for a small register-file FIFO built from a bank of DEPTH 8-bit write-enabled registers.
- Converts push/pop requests into a one-hot-free write strobe plus a write address for the register bank, and a read address for the output mux.
- Maintains occupancy, full/empty, almost-full/almost-empty and sticky overflow/underflow status.
- Sits between the producer/consumer interfaces and the storage registers in the SRAM/FIFO datapath.

Parameters:
- DEPTH, 8, number of 8-bit storage registers; legal range 2..256; need not be a power of two.
- ADDR_W, $clog2(DEPTH), pointer width.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request; data is presented to the register bank by the producer this cycle.
- pop  in  1  read request; consumer takes rd_addr's register output this cycle.
- clr  in  1  synchronous flush; pointers and count go to 0, sticky flags are cleared.
- wr_en  out  1  write strobe to the register bank (w_en of register wr_addr).
- wr_addr  out  ADDR_W  register index to write.
- rd_addr  out  ADDR_W  register index driving read data.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Outputs: wr_en=0, wr_addr=0, rd_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for default AF_LEVEL). Reset mid-operation discards all contents.
- Registered state: wr_ptr, rd_ptr, count, overflow, underflow. wr_addr=wr_ptr and rd_addr=rd_ptr directly.
- Flags are combinational decodes of the registered count, so they update the cycle after the causing edge.
- Acceptance (combinational):
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
- wr_en = push_ok & ~clr. It is combinational, so the bank captures data at the same edge the pointer advances; write latency is 1 cycle.
- Read data is valid while empty=0. It is combinational from the bank via rd_addr. After pop_ok, the next entry is visible the following cycle.
- Pointer advance on an accepted operation: ptr <= (ptr == DEPTH-1) ? 0 : ptr+1. This explicit wrap is required for non-power-of-two DEPTH.
- Count update:
  - push_ok only: +1
  - pop_ok only: -1
  - both or neither: unchanged
- Full with push and pop together: both are accepted. The oldest entry is read, the freed slot (wr_ptr == rd_ptr) is written, and count stays DEPTH.
- Empty with push and pop together: push accepted, pop rejected, underflow set. No read-through.
- Push while full without pop: rejected, wr_en=0, overflow <= 1, state unchanged.
- Pop while empty: rejected, underflow <= 1.
- Sticky flags clear only on rst or clr.
- clr has priority over push/pop in the same cycle:
  - pointers, count and sticky flags go to 0;
  - wr_en is forced 0;
  - the requests are ignored and do not set sticky flags.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except that count==DEPTH when the pointers are equal and the FIFO is full.

Decomposition:
- Package fifo_pkg holds:
  - the DATA_W=8 constant;
  - a typedef for the status bundle (full, empty, almost_full, almost_empty, overflow, underflow) as a packed struct, for reuse by the top-level FIFO and the UVM monitor.
- Sub-module fifo_ptr(DEPTH): one wrapping pointer with inc and clr inputs. It is instantiated twice, for write and read.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, wr_addr=rd_addr=0, wr_en=0.
- Push 8 consecutive (DEPTH=8) -> count 1..8, almost_full at count=6, full at count=8, wr_addr sequence 0..7. A 9th push gives wr_en=0, overflow=1, count=8.
- Full, then push+pop for 3 cycles -> count stays 8, rd_addr 0→1→2→3, wr_addr 0→1→2→3, wr_en=1 each cycle, overflow not newly set.
- Drain all, then pop on empty -> underflow=1, rd_addr unchanged. Push+pop on empty -> count=1, underflow stays set.
- DEPTH=5 build: 7 push/pop pairs -> pointers wrap 4→0, never reach 5 or above, and count stays 0..5.
- Mid-fill (count=4): assert clr with push=1 -> next cycle count=0, pointers 0, wr_en=0 during clr, overflow/underflow 0. Then assert rst asynchronously mid-cycle -> outputs at reset values immediately.
